axi_rd_rr_arbiter: RTL and testbench

- Shares one AXI4 read port, e.g. the slave side of the striped SRAM stripe block, between NUM_M read masters (perf generators, video fetch, debug readers).
- Round-robin grant per read burst.
- One burst outstanding at a time.
- AR fields, R data, RID and RRESP pass through unmodified.
- Sits between the masters and the stripe/SRAM subsystem; the write channels are handled by a separate block.

---
 rtl/axi_rd_rr_arbiter.sv | 86 ++++++++
 tb/tb_axi_rd_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_rr_arbiter.sv
// axi_rd_rr_arbiter: round-robin share of one AXI4 read port, one burst in flight at a time
module axi_rd_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_M-1:0] s_axi_arvalid,
  input  logic [NUM_M-1:0][AXI_ID_WIDTH-1:0] s_axi_arid,
  input  logic [NUM_M-1:0][AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [NUM_M-1:0][7:0] s_axi_arlen,
  input  logic [NUM_M-1:0][2:0] s_axi_arsize,
  input  logic [NUM_M-1:0][1:0] s_axi_arburst,
  output logic [NUM_M-1:0] s_axi_arready,
  output logic [NUM_M-1:0] s_axi_rvalid,
  output logic [AXI_ID_WIDTH-1:0] s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0] s_axi_rresp,
  output logic s_axi_rlast,
  input  logic [NUM_M-1:0] s_axi_rready,
  output logic m_axi_arvalid,
  output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0] m_axi_arlen,
  output logic [2:0] m_axi_arsize,
  output logic [1:0] m_axi_arburst,
  input  logic m_axi_arready,
  input  logic m_axi_rvalid,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0] m_axi_rresp,
  input  logic m_axi_rlast,
  output logic m_axi_rready
);
  localparam int IW = NUM_M > 1 ? $clog2(NUM_M) : 1;
  localparam logic [IW:0] NM = (IW+1)'(NUM_M);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, grant_idx, pick;
  logic [IW:0] cand;
  // scan offsets high to low so the nearest requester after rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int i = NUM_M-1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      cand = cand >= NM ? cand - NM : cand;
      pick = s_axi_arvalid[cand[IW-1:0]] ? cand[IW-1:0] : pick;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
    end else begin
      unique case (state)
        IDLE: if (|s_axi_arvalid) begin
          grant_idx <= pick;
          state <= ADDR;
        end
        ADDR: if (m_axi_arready) state <= DATA;
        DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
          state <= IDLE;
          rr_ptr <= grant_idx == IW'(NUM_M-1) ? '0 : grant_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign m_axi_arvalid = state == ADDR;
  assign m_axi_arid = s_axi_arid[grant_idx];
  assign m_axi_araddr = s_axi_araddr[grant_idx];
  assign m_axi_arlen = s_axi_arlen[grant_idx];
  assign m_axi_arsize = s_axi_arsize[grant_idx];
  assign m_axi_arburst = s_axi_arburst[grant_idx];
  assign s_axi_arready = (state == ADDR && m_axi_arready) ? NUM_M'(1) << grant_idx : '0;
  assign s_axi_rvalid = (state == DATA && m_axi_rvalid) ? NUM_M'(1) << grant_idx : '0;
  assign m_axi_rready = state == DATA && s_axi_rready[grant_idx];
  assign s_axi_rid = m_axi_rid;
  assign s_axi_rdata = m_axi_rdata;
  assign s_axi_rresp = m_axi_rresp;
  assign s_axi_rlast = m_axi_rlast;
endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// tb_axi_rd_rr_arbiter: vector table, directed corner sequences and a randomized run against a reference model
module tb_axi_rd_rr_arbiter;
  localparam int N = 3;
  localparam int AW = 21;
  localparam int DW = 16;
  localparam int IW = 4;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  logic [N-1:0] s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [N-1:0][IW-1:0] s_axi_arid;
  logic [N-1:0][AW-1:0] s_axi_araddr;
  logic [N-1:0][7:0] s_axi_arlen;
  logic [N-1:0][2:0] s_axi_arsize;
  logic [N-1:0][1:0] s_axi_arburst;
  logic [IW-1:0] s_axi_rid, m_axi_arid, m_axi_rid;
  logic [DW-1:0] s_axi_rdata, m_axi_rdata;
  logic [1:0] s_axi_rresp, m_axi_rresp, m_axi_arburst;
  logic s_axi_rlast, m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  axi_rd_rr_arbiter #(.NUM_M(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arready(s_axi_arready), .s_axi_rvalid(s_axi_rvalid), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rready(s_axi_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready)
  );
  typedef struct {logic [N-1:0] req; int len; int g;} vec_t;
  vec_t tbl[10];
  int n_cmp = 0;
  int n_fail = 0;
  int g, sent, c, mph, mptr, mg, left, clr, p;
  logic [1:0] gi;
  logic [DW-1:0] got[$];
  logic e_arv, e_rr;
  logic [N-1:0] e_arr, e_rv;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    int k = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin r = i; k++; end
    return k == 1 ? r : -1;
  endfunction
  // reference arbitration: first requester scanning ptr, ptr+1, ... modulo N
  function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = req >> ((ptr + k) % N);
      if (sh[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction
  task automatic do_reset();
    rst = 1;
    s_axi_arvalid = '0;
    s_axi_rready = '0;
    m_axi_arready = 0;
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", 64'({m_axi_arvalid, m_axi_rready, s_axi_arready, s_axi_rvalid}), 64'(0));
    rst = 0;
  endtask
  task automatic serve(input int len, input bit keep, output int gr);
    int t = 0;
    logic [1:0] gl;
    gr = -1;
    m_axi_arready = 1;
    s_axi_rready = '1;
    @(negedge clk);
    #1;
    while (!m_axi_arvalid && t < 20) begin
      @(negedge clk);
      #1 t++;
    end
    if (!m_axi_arvalid) begin
      chk("ar_timeout", 64'(0), 64'(1));
      return;
    end
    gr = oh_idx(s_axi_arready);
    if (gr < 0) begin
      chk("arready_onehot", 64'(s_axi_arready), 64'(0));
      return;
    end
    gl = 2'(gr);
    chk("serve_araddr", 64'(m_axi_araddr), 64'(s_axi_araddr[gl]));
    @(negedge clk);
    if (!keep) s_axi_arvalid = '0;
    for (int b = 0; b <= len; b++) begin
      m_axi_rvalid = 1;
      m_axi_rlast = b == len;
      m_axi_rdata = DW'(b);
      #1 chk("serve_rvalid", 64'(s_axi_rvalid), 64'(N'(1) << gl));
      @(negedge clk);
    end
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
  endtask
  initial begin
    tbl = '{'{3'b111, 0, 0}, '{3'b111, 1, 1}, '{3'b111, 2, 2}, '{3'b110, 0, 1}, '{3'b001, 1, 0},
            '{3'b001, 0, 0}, '{3'b101, 3, 2}, '{3'b100, 0, 2}, '{3'b011, 1, 0}, '{3'b100, 0, 2}};
    m_axi_rid = '0;
    m_axi_rdata = '0;
    m_axi_rresp = '0;
    for (int i = 0; i < N; i++) begin
      s_axi_arid[i] = IW'(i);
      s_axi_araddr[i] = AW'(32'h1000 * (i + 1));
      s_axi_arlen[i] = '0;
      s_axi_arsize[i] = 3'd1;
      s_axi_arburst[i] = 2'd1;
    end
    do_reset();
    // single master, single beat
    @(negedge clk);
    s_axi_arvalid = 3'b001;
    s_axi_araddr[0] = AW'(32'h100);
    s_axi_arid[0] = 4'd3;
    #1 chk("a_idle_arvalid", 64'(m_axi_arvalid), 64'(0));
    @(negedge clk);
    #1 chk("a_latency", 64'(m_axi_arvalid), 64'(1));
    chk("a_ar", 64'({m_axi_araddr, m_axi_arid, m_axi_arlen}), 64'({AW'(32'h100), 4'd3, 8'd0}));
    chk("a_arready_stall", 64'(s_axi_arready), 64'(0));
    m_axi_arready = 1;
    #1 chk("a_arready", 64'(s_axi_arready), 64'(3'b001));
    @(negedge clk);
    s_axi_arvalid = '0;
    m_axi_arready = 0;
    s_axi_rready = '1;
    m_axi_rvalid = 1;
    m_axi_rid = 4'd3;
    m_axi_rlast = 1;
    m_axi_rdata = 16'hbeef;
    #1 chk("a_rvalid", 64'(s_axi_rvalid), 64'(3'b001));
    chk("a_r", 64'({s_axi_rid, s_axi_rlast, s_axi_rdata, m_axi_rready}), 64'({4'd3, 1'b1, 16'hbeef, 1'b1}));
    @(negedge clk);
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    #1 chk("a_back_idle", 64'({m_axi_arvalid, m_axi_rready, s_axi_rvalid}), 64'(0));
    // two masters contend right after reset
    do_reset();
    s_axi_arvalid = 3'b011;
    s_axi_arlen[0] = 8'd3;
    s_axi_arlen[1] = 8'd3;
    s_axi_araddr[0] = AW'(32'h1000);
    m_axi_arready = 1;
    s_axi_rready = '1;
    #1 chk("b_idle", 64'(m_axi_arvalid), 64'(0));
    @(negedge clk);
    #1 chk("b_grant0", 64'(s_axi_arready), 64'(3'b001));
    chk("b_addr0", 64'(m_axi_araddr), 64'(32'h1000));
    @(negedge clk);
    s_axi_arvalid = 3'b010;
    for (int b = 0; b < 4; b++) begin
      m_axi_rvalid = 1;
      m_axi_rlast = b == 3;
      #1 chk("b_rv0", 64'({s_axi_rvalid, s_axi_arready}), 64'({3'b001, 3'b000}));
      @(negedge clk);
    end
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    #1 chk("b_gap", 64'({m_axi_arvalid, s_axi_arready}), 64'(0));
    @(negedge clk);
    #1 chk("b_grant1", 64'({m_axi_arvalid, s_axi_arready}), 64'({1'b1, 3'b010}));
    chk("b_addr1", 64'(m_axi_araddr), 64'(32'h2000));
    @(negedge clk);
    s_axi_arvalid = '0;
    for (int b = 0; b < 4; b++) begin
      m_axi_rvalid = 1;
      m_axi_rlast = b == 3;
      #1 chk("b_rv1", 64'(s_axi_rvalid), 64'(3'b010));
      @(negedge clk);
    end
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    // arbitration table, pointer carried from vector to vector
    do_reset();
    for (int v = 0; v < 10; v++) begin
      s_axi_arvalid = tbl[v].req;
      serve(tbl[v].len, 0, g);
      chk($sformatf("tbl_grant%0d", v), 64'(g), 64'(tbl[v].g));
    end
    // continuous requests rotate
    s_axi_arvalid = '1;
    for (int k = 0; k < 6; k++) begin
      serve(0, 1, g);
      chk($sformatf("rot%0d", k), 64'(g), 64'(k % N));
    end
    s_axi_arvalid = '0;
    // backpressure from both sides mid-burst
    s_axi_arvalid = 3'b001;
    s_axi_arlen[0] = 8'd7;
    m_axi_arready = 1;
    @(negedge clk);
    #1 chk("d_grant", 64'(s_axi_arready), 64'(3'b001));
    @(negedge clk);
    s_axi_arvalid = '0;
    sent = 0;
    c = 0;
    got.delete();
    while (got.size() < 8 && c < 40) begin
      s_axi_rready = {2'($urandom), !(c >= 2 && c <= 4)};
      m_axi_rvalid = !(c == 6 || c == 7) && sent < 8;
      m_axi_rlast = sent == 7;
      m_axi_rdata = DW'(16'h500 + sent);
      #1 chk("d_rready", 64'(m_axi_rready), 64'(s_axi_rready[0]));
      chk("d_rvalid", 64'(s_axi_rvalid), 64'({2'b00, m_axi_rvalid}));
      if (s_axi_rvalid[0] && s_axi_rready[0]) got.push_back(s_axi_rdata);
      if (m_axi_rvalid && m_axi_rready) sent++;
      c++;
      @(negedge clk);
    end
    m_axi_rvalid = 0;
    m_axi_rlast = 0;
    chk("d_count", 64'(got.size()), 64'(8));
    for (int i = 0; i < got.size(); i++) chk($sformatf("d_beat%0d", i), 64'(got[i]), 64'(16'h500 + i));
    // reset in the middle of a burst
    s_axi_arvalid = 3'b010;
    s_axi_arlen[1] = 8'd7;
    m_axi_arready = 1;
    s_axi_rready = '1;
    @(negedge clk);
    #1 chk("e_grant", 64'(s_axi_arready), 64'(3'b010));
    @(negedge clk);
    s_axi_arvalid = '0;
    m_axi_arready = 0;
    m_axi_rvalid = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    s_axi_arvalid = 3'b011;
    #1 chk("e_rst_outs", 64'({m_axi_arvalid, m_axi_rready, s_axi_arready, s_axi_rvalid}), 64'(0));
    m_axi_rvalid = 0;
    serve(0, 0, g);
    chk("e_grant_after", 64'(g), 64'(0));
    // randomized traffic against the reference model
    do_reset();
    mph = 0;
    mptr = 0;
    mg = 0;
    left = 0;
    clr = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (clr >= 0) begin
        s_axi_arvalid[2'(clr)] = 0;
        clr = -1;
      end
      for (int i = 0; i < N; i++)
        if (!s_axi_arvalid[i] && $urandom_range(0, 2) == 0) begin
          s_axi_arvalid[i] = 1;
          s_axi_araddr[i] = AW'($urandom);
          s_axi_arlen[i] = 8'($urandom_range(0, 3));
          s_axi_arsize[i] = 3'($urandom);
          s_axi_arburst[i] = 2'($urandom);
        end
      m_axi_arready = 1'($urandom_range(0, 1));
      s_axi_rready = N'($urandom);
      m_axi_rvalid = (mph == 2 && left > 0) ? $urandom_range(0, 3) != 0 : 1'b0;
      m_axi_rlast = left == 1;
      m_axi_rdata = DW'($urandom);
      m_axi_rid = IW'($urandom);
      m_axi_rresp = 2'($urandom);
      #1;
      gi = 2'(mg);
      e_arv = mph == 1;
      e_arr = (mph == 1 && m_axi_arready) ? N'(1) << gi : '0;
      e_rv = (mph == 2 && m_axi_rvalid) ? N'(1) << gi : '0;
      e_rr = mph == 2 && s_axi_rready[gi];
      chk("rnd_hs", 64'({m_axi_arvalid, s_axi_arready, s_axi_rvalid, m_axi_rready}), 64'({e_arv, e_arr, e_rv, e_rr}));
      if (mph == 1)
        chk("rnd_ar", 64'({m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst}),
            64'({s_axi_araddr[gi], s_axi_arlen[gi], s_axi_arid[gi], s_axi_arsize[gi], s_axi_arburst[gi]}));
      chk("rnd_r", 64'({s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'({m_axi_rdata, m_axi_rid, m_axi_rresp, m_axi_rlast}));
      if (mph == 0) begin
        p = rr_pick(mptr, s_axi_arvalid);
        if (p >= 0) begin
          mg = p;
          mph = 1;
        end
      end else if (mph == 1) begin
        if (m_axi_arready) begin
          mph = 2;
          left = int'(s_axi_arlen[gi]) + 1;
          clr = mg;
        end
      end else if (m_axi_rvalid && s_axi_rready[gi]) begin
        left--;
        if (left == 0) begin
          mph = 0;
          mptr = (mg + 1) % N;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
